// File: rtl/swt16_pkg.sv
// swt16_pkg: constants and types shared by the swt16 core blocks.
//   PC_WIDTH / PMEM_ADDR_WIDTH / PMEM_WORD_WIDTH / IALU_WORD_WIDTH : bus widths
//   fetch_state_t : fetch stage state encoding (BOOT, RUN, FLUSH)
//   NOP_WORD      : word handed to the decoder when nothing valid is fetched
package swt16_pkg;

  localparam int PC_WIDTH        = 12;
  localparam int PMEM_ADDR_WIDTH = 12;
  localparam int PMEM_WORD_WIDTH = 16;
  localparam int IALU_WORD_WIDTH = 16;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [15:0] NOP_WORD = 16'h0000;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the swt16 core.
// Drives a word-addressed PMEM with a one-cycle synchronous read and presents
// the returned word with its PC to the decoder.
// Ports:
//   clock, reset        : clock, asynchronous active-high reset
//   in_stall            : decoder not consuming; hold the presented word
//   in_jump             : taken jump from execute (redirect)
//   in_jump_target      : jump destination, low PC_WIDTH bits used
//   out_pmem_addr       : PMEM read address for this cycle
//   in_pmem_rdata       : PMEM data for the address issued last cycle
//   out_instr / out_pc  : fetched word and its address
//   out_valid           : out_instr/out_pc carry a real fetched word
//   out_flush           : decoder flush request (boot and redirect bubbles)
module fetch_unit #(
  parameter int PMEM_ADDR_WIDTH = swt16_pkg::PMEM_ADDR_WIDTH,
  parameter int PMEM_WORD_WIDTH = swt16_pkg::PMEM_WORD_WIDTH,
  parameter int PC_WIDTH        = swt16_pkg::PC_WIDTH,
  parameter int IALU_WORD_WIDTH = swt16_pkg::IALU_WORD_WIDTH,
  parameter int FLUSH_CYCLES    = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_stall,
  input  logic                       in_jump,
  input  logic [IALU_WORD_WIDTH-1:0] in_jump_target,
  output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr,
  input  logic [PMEM_WORD_WIDTH-1:0] in_pmem_rdata,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic                       out_valid,
  output logic                       out_flush
);

  import swt16_pkg::*;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] pc_fetch;
  logic [PC_WIDTH-1:0] pc_resp;
  logic [2:0]          flush_cnt;

  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] jump_pc;
  logic [PC_WIDTH-1:0] addr_sel;
  logic                stall_run;

  // Increment wraps naturally modulo 2^PC_WIDTH.
  assign pc_next   = pc_fetch + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  assign jump_pc   = in_jump_target[PC_WIDTH-1:0];
  // A stall only matters in RUN; BOOT and FLUSH keep fetching.
  assign stall_run = in_stall & (state == RUN);

  generate
    if (IALU_WORD_WIDTH > PC_WIDTH) begin : g_target_upper
      logic unused_target_upper;
      assign unused_target_upper = ^in_jump_target[IALU_WORD_WIDTH-1:PC_WIDTH];
    end
  endgenerate

  // Address mux: re-issue the held address while stalled so the same word
  // comes back next cycle without a skid buffer.
  always_comb begin
    addr_sel = pc_fetch;
    if (stall_run) begin
      addr_sel = pc_resp;
    end else begin
      addr_sel = pc_fetch;
    end
  end

  assign out_pmem_addr = PMEM_ADDR_WIDTH'(addr_sel);
  assign out_valid     = (state == RUN);
  assign out_flush     = (state != RUN);
  assign out_pc        = pc_resp;
  assign out_instr     = out_valid ? in_pmem_rdata : PMEM_WORD_WIDTH'(NOP_WORD);

  // Fetch sequencer: PC pipeline, boot, stall hold and redirect/flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= BOOT;
      pc_fetch  <= {PC_WIDTH{1'b0}};
      pc_resp   <= {PC_WIDTH{1'b0}};
      flush_cnt <= 3'd0;
    end else if (in_jump) begin
      // Redirect wins over stall and restarts any flush in progress.
      pc_fetch  <= jump_pc;
      pc_resp   <= pc_fetch;
      state     <= FLUSH;
      flush_cnt <= FLUSH_RELOAD;
    end else begin
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_resp  <= pc_fetch;
          pc_fetch <= pc_next;
        end
        RUN: begin
          if (!in_stall) begin
            pc_resp  <= pc_fetch;
            pc_fetch <= pc_next;
          end
        end
        FLUSH: begin
          // pc_fetch stays on the target until the last flush cycle, so the
          // target is re-issued then and becomes the first valid word.
          if (flush_cnt == 3'd0) begin
            state    <= RUN;
            pc_resp  <= pc_fetch;
            pc_fetch <= pc_next;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: begin
          state     <= BOOT;
          pc_fetch  <= {PC_WIDTH{1'b0}};
          pc_resp   <= {PC_WIDTH{1'b0}};
          flush_cnt <= 3'd0;
        end
      endcase
    end
  end

endmodule
